// File: rtl/int_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | int_pkg : shared types and defaults for the interrupt controller      |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package int_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SAVE      = 3'd1,
        ST_JUMP      = 3'd2,
        ST_RESTORE   = 3'd3,
        ST_WAIT_CTXT = 3'd4,
        ST_RESUME    = 3'd5
    } state_t;

    localparam logic [15:0] C_ISR_BASE_DFLT   = 16'h0100;
    localparam logic [15:0] C_ISR_STRIDE_DFLT = 16'h0040;

    // Depth counter must hold the value STACK_DEPTH itself (the full state).
    function automatic int depth_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/int_prio_enc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | int_prio_enc : lowest-index-first priority encoder with valid flag    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module int_prio_enc #(
    parameter int WIDTH = 4,
    parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] i_req,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_idx
);

    // Scan from the top so the last hit is the lowest set index.
    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_valid = 1'b1;
                o_idx   = IDX_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/int_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | int_ctrl : nesting interrupt controller driving the context stack     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module int_ctrl
    import int_pkg::*;
#(
    parameter int          NUM_IRQ        = 4,
    parameter int          ADDR_WIDTH_MEM = 16,
    parameter int          STACK_DEPTH    = 8,
    parameter logic [15:0] ISR_BASE       = C_ISR_BASE_DFLT,
    parameter logic [15:0] ISR_STRIDE     = C_ISR_STRIDE_DFLT,
    parameter int          CTXT_TIMEOUT   = 15
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_IRQ-1:0]            irq_req,
    input  logic [NUM_IRQ-1:0]            irq_mask,
    input  logic                          instr_boundary,
    input  logic [ADDR_WIDTH_MEM-1:0]     pc_next,
    input  logic                          reti,
    input  logic                          ctxt_rdy,
    input  logic [ADDR_WIDTH_MEM-1:0]     ret_addr_ret,
    output logic                          int_set,
    output logic                          ret_valid,
    output logic [ADDR_WIDTH_MEM-1:0]     ret_addr,
    output logic                          jump_valid,
    output logic [ADDR_WIDTH_MEM-1:0]     jump_addr,
    output logic [NUM_IRQ-1:0]            irq_ack,
    output logic [$clog2(STACK_DEPTH):0]  nest_depth,
    output logic                          busy,
    output logic                          err_underflow,
    output logic                          err_timeout
);

    localparam int ID_W    = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
    localparam int DEPTH_W = depth_width(STACK_DEPTH);
    localparam int CNT_W   = $clog2(CTXT_TIMEOUT + 1);

    localparam logic [DEPTH_W-1:0] C_DEPTH_MAX = DEPTH_W'(STACK_DEPTH);
    localparam logic [CNT_W-1:0]   C_TIMEOUT   = CNT_W'(CTXT_TIMEOUT);
    localparam logic [NUM_IRQ-1:0] C_ONE       = NUM_IRQ'(1);

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [NUM_IRQ-1:0]        r_in_service;
    logic [ID_W-1:0]           r_id;
    logic [CNT_W-1:0]          r_cnt;
    logic [DEPTH_W-1:0]        r_nest_depth;
    logic                      r_int_set;
    logic                      r_ret_valid;
    logic                      r_jump_valid;
    logic                      r_busy;
    logic                      r_err_underflow;
    logic                      r_err_timeout;
    logic [NUM_IRQ-1:0]        r_irq_ack;
    logic [ADDR_WIDTH_MEM-1:0] r_ret_addr;
    logic [ADDR_WIDTH_MEM-1:0] r_jump_addr;

    logic                      w_cand_valid;
    logic [ID_W-1:0]           w_cand;
    logic                      w_isv_valid;
    logic [ID_W-1:0]           w_isv_idx;
    logic                      w_eligible;
    logic                      w_underflow;
    logic                      w_timeout;
    logic [CNT_W-1:0]          w_cnt_inc;
    logic [ADDR_WIDTH_MEM-1:0] w_vec_addr;

    int_prio_enc #(.WIDTH(NUM_IRQ), .IDX_W(ID_W)) u_cand_enc (
        .i_req   (irq_req & irq_mask),
        .o_valid (w_cand_valid),
        .o_idx   (w_cand)
    );

    int_prio_enc #(.WIDTH(NUM_IRQ), .IDX_W(ID_W)) u_isv_enc (
        .i_req   (r_in_service),
        .o_valid (w_isv_valid),
        .o_idx   (w_isv_idx)
    );

    // A request may only preempt a strictly higher-priority (lower index) level.
    assign w_eligible = w_cand_valid && instr_boundary &&
                        (!w_isv_valid || (w_cand < w_isv_idx)) &&
                        (r_nest_depth < C_DEPTH_MAX);
    assign w_cnt_inc  = r_cnt + 1'b1;
    assign w_vec_addr = ADDR_WIDTH_MEM'(32'(ISR_BASE) + 32'(r_id) * 32'(ISR_STRIDE));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_underflow = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (reti) begin
                    if (r_nest_depth != '0) begin
                        w_state_nxt = ST_RESTORE;
                    end else begin
                        w_underflow = 1'b1;
                    end
                end else if (w_eligible) begin
                    w_state_nxt = ST_SAVE;
                end
            end
            ST_SAVE:    w_state_nxt = ST_JUMP;
            ST_JUMP:    w_state_nxt = ST_IDLE;
            ST_RESTORE: w_state_nxt = ST_WAIT_CTXT;
            ST_WAIT_CTXT: begin
                if (ctxt_rdy) begin
                    w_state_nxt = ST_RESUME;
                end else if (w_cnt_inc == C_TIMEOUT) begin
                    w_state_nxt = ST_IDLE;
                    w_timeout   = 1'b1;
                end
            end
            ST_RESUME:  w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // Strobes are registered from the next state so they align with the state cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_in_service    <= '0;
            r_id            <= '0;
            r_cnt           <= '0;
            r_nest_depth    <= '0;
            r_int_set       <= 1'b0;
            r_ret_valid     <= 1'b0;
            r_jump_valid    <= 1'b0;
            r_busy          <= 1'b0;
            r_err_underflow <= 1'b0;
            r_err_timeout   <= 1'b0;
            r_irq_ack       <= '0;
            r_ret_addr      <= '0;
            r_jump_addr     <= '0;
        end else begin
            r_int_set    <= (w_state_nxt == ST_SAVE);
            r_ret_valid  <= (w_state_nxt == ST_RESTORE);
            r_jump_valid <= (w_state_nxt == ST_JUMP) || (w_state_nxt == ST_RESUME);
            r_busy       <= (w_state_nxt != ST_IDLE);
            r_irq_ack    <= (w_state_nxt == ST_SAVE) ? (C_ONE << w_cand) : '0;

            if ((r_state == ST_IDLE) && (w_state_nxt == ST_SAVE)) begin
                r_ret_addr <= pc_next;
                r_id       <= w_cand;
            end
            if (r_state == ST_SAVE) begin
                r_in_service <= r_in_service | (C_ONE << r_id);
                r_nest_depth <= r_nest_depth + 1'b1;
            end
            if (r_state == ST_RESTORE) begin
                r_in_service <= r_in_service & ~(C_ONE << w_isv_idx);
                r_nest_depth <= r_nest_depth - 1'b1;
                r_cnt        <= '0;
            end
            if ((r_state == ST_WAIT_CTXT) && !ctxt_rdy) begin
                r_cnt <= w_cnt_inc;
            end
            if (w_state_nxt == ST_JUMP) begin
                r_jump_addr <= w_vec_addr;
            end
            if (w_state_nxt == ST_RESUME) begin
                r_jump_addr <= ret_addr_ret;
            end
            if (w_underflow) begin
                r_err_underflow <= 1'b1;
            end
            if (w_timeout) begin
                r_err_timeout <= 1'b1;
            end
        end
    end

    assign int_set       = r_int_set;
    assign ret_valid     = r_ret_valid;
    assign ret_addr      = r_ret_addr;
    assign jump_valid    = r_jump_valid;
    assign jump_addr     = r_jump_addr;
    assign irq_ack       = r_irq_ack;
    assign nest_depth    = r_nest_depth;
    assign busy          = r_busy;
    assign err_underflow = r_err_underflow;
    assign err_timeout   = r_err_timeout;

endmodule
`default_nettype wire

// File: tb/tb_int_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_int_ctrl : directed + random bench for int_ctrl with a stack model |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_int_ctrl;

    // More lines than stack entries, so the full-stack condition is reachable.
    localparam int N  = 12;
    localparam int AW = 16;
    localparam int SD = 8;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [N-1:0]  irq_req = '0;
    logic [N-1:0]  irq_mask = '0;
    logic          instr_boundary = 1'b0;
    logic [AW-1:0] pc_next = '0;
    logic          reti = 1'b0;
    logic          ctxt_rdy = 1'b0;
    logic [AW-1:0] ret_addr_ret = '0;
    logic          int_set;
    logic          ret_valid;
    logic [AW-1:0] ret_addr;
    logic          jump_valid;
    logic [AW-1:0] jump_addr;
    logic [N-1:0]  irq_ack;
    logic [3:0]    nest_depth;
    logic          busy;
    logic          err_underflow;
    logic          err_timeout;

    int_ctrl #(
        .NUM_IRQ        (N),
        .ADDR_WIDTH_MEM (AW),
        .STACK_DEPTH    (SD),
        .ISR_BASE       (16'h0100),
        .ISR_STRIDE     (16'h0040),
        .CTXT_TIMEOUT   (TO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .irq_req        (irq_req),
        .irq_mask       (irq_mask),
        .instr_boundary (instr_boundary),
        .pc_next        (pc_next),
        .reti           (reti),
        .ctxt_rdy       (ctxt_rdy),
        .ret_addr_ret   (ret_addr_ret),
        .int_set        (int_set),
        .ret_valid      (ret_valid),
        .ret_addr       (ret_addr),
        .jump_valid     (jump_valid),
        .jump_addr      (jump_addr),
        .irq_ack        (irq_ack),
        .nest_depth     (nest_depth),
        .busy           (busy),
        .err_underflow  (err_underflow),
        .err_timeout    (err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            id;
        logic [AW-1:0] pc;
    } frame_t;

    frame_t        stk[$];
    logic          m_uf = 1'b0;
    logic          m_to = 1'b0;
    logic [AW-1:0] m_ret_addr = '0;
    int            errors = 0;
    int            checks = 0;
    logic [N-1:0]  c_all = '1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int lowest(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // Accept only at a boundary, with room on the stack, preempting the running ISR.
    function automatic bit m_eligible(input logic [N-1:0] req, input logic [N-1:0] mask,
                                      input logic bnd);
        int c;
        c = lowest(req & mask);
        if (c < 0 || !bnd) return 1'b0;
        if (stk.size() >= SD) return 1'b0;
        if (stk.size() > 0 && c >= stk[$].id) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [AW-1:0] vec(input int id);
        return AW'(32'h0100 + id * 32'h0040);
    endfunction

    task automatic chk_flags();
        chk("err_underflow", err_underflow, m_uf);
        chk("err_timeout", err_timeout, m_to);
    endtask

    task automatic do_irq(input logic [N-1:0] req, input logic [N-1:0] mask,
                          input logic bnd, input logic [AW-1:0] pc);
        int           c;
        bit           e;
        logic [N-1:0] oh;
        c  = lowest(req & mask);
        e  = m_eligible(req, mask, bnd);
        oh = '0;
        irq_req = req; irq_mask = mask; instr_boundary = bnd; pc_next = pc;
        step();
        irq_req = '0; instr_boundary = 1'b0;
        if (e) begin
            oh[c] = 1'b1;
            chk("int_set", int_set, 1);
            chk("irq_ack", irq_ack, oh);
            chk("ret_addr", ret_addr, pc);
            chk("busy_save", busy, 1);
            stk.push_back('{id: c, pc: pc});
            m_ret_addr = pc;
            step();
            chk("int_set_pulse", int_set, 0);
            chk("irq_ack_pulse", irq_ack, 0);
            chk("jump_valid", jump_valid, 1);
            chk("jump_addr", jump_addr, vec(c));
            chk("nest_depth_inc", nest_depth, stk.size());
            step();
            chk("jump_pulse", jump_valid, 0);
            chk("idle_after_jump", busy, 0);
        end else begin
            chk("no_int_set", int_set, 0);
            chk("no_ack", irq_ack, 0);
            chk("stay_idle", busy, 0);
            chk("depth_hold", nest_depth, stk.size());
            chk("ret_addr_hold", ret_addr, m_ret_addr);
        end
    endtask

    // wcyc = WAIT_CTXT cycles before the stack answers; >= TO means it never does.
    task automatic do_reti(input int wcyc, input logic [N-1:0] req);
        frame_t f;
        reti = 1'b1; irq_req = req; irq_mask = c_all; instr_boundary = 1'b1;
        step();
        reti = 1'b0;
        chk("no_int_set_on_reti", int_set, 0);
        if (stk.size() == 0) begin
            m_uf = 1'b1;
            chk("no_ret_valid", ret_valid, 0);
            chk("underflow_idle", busy, 0);
            return;
        end
        f = stk.pop_back();
        chk("ret_valid", ret_valid, 1);
        chk("busy_restore", busy, 1);
        chk("ret_addr_stable", ret_addr, m_ret_addr);
        step();
        chk("ret_valid_pulse", ret_valid, 0);
        chk("nest_depth_dec", nest_depth, stk.size());
        for (int k = 0; k < TO; k++) begin
            if (k == wcyc) begin
                ctxt_rdy = 1'b1; ret_addr_ret = f.pc;
                step();
                ctxt_rdy = 1'b0; ret_addr_ret = AW'($urandom);
                chk("resume_jump_valid", jump_valid, 1);
                chk("resume_jump_addr", jump_addr, f.pc);
                step();
                chk("resume_pulse", jump_valid, 0);
                chk("idle_after_resume", busy, 0);
                return;
            end
            ret_addr_ret = AW'($urandom);
            step();
            if (k < TO - 1) chk("wait_busy", busy, 1);
        end
        m_to = 1'b1;
        chk("timeout_flag", err_timeout, 1);
        chk("timeout_idle", busy, 0);
        chk("timeout_no_jump", jump_valid, 0);
    endtask

    initial begin
        repeat (3) step();
        chk("rst_int_set", int_set, 0);
        chk("rst_ret_valid", ret_valid, 0);
        chk("rst_ret_addr", ret_addr, 0);
        chk("rst_jump_valid", jump_valid, 0);
        chk("rst_jump_addr", jump_addr, 0);
        chk("rst_irq_ack", irq_ack, 0);
        chk("rst_nest_depth", nest_depth, 0);
        chk("rst_busy", busy, 0);
        chk_flags();
        rst = 1'b1;
        step();

        do_irq(N'(4'b0100), c_all, 1'b1, 16'h0020);
        do_irq(N'(4'b1000), c_all, 1'b1, 16'h0300);
        do_irq(N'(4'b1010), c_all, 1'b1, 16'h0304);
        do_reti(1, '0);
        do_reti(1, '0);
        chk_flags();

        do_reti(0, '0);
        chk_flags();
        do_irq(N'(4'b1000), c_all, 1'b1, 16'h0400);
        do_reti(1, N'(4'b0001));
        do_irq(N'(4'b0001), c_all, 1'b1, 16'h0410);
        do_reti(0, '0);
        do_irq(N'(4'b0001), ~N'(4'b0001), 1'b1, 16'h0420);
        do_irq(N'(4'b0001), c_all, 1'b0, 16'h0430);

        for (int i = N - 1; i >= N - SD; i--) begin
            do_irq(N'(1) << i, c_all, 1'b1, AW'($urandom));
        end
        chk("full_depth", nest_depth, SD);
        do_irq(N'(4'b1000), c_all, 1'b1, 16'h0500);
        do_reti(2, '0);
        do_irq(N'(4'b1000), c_all, 1'b1, 16'h0504);
        while (stk.size() > 0) do_reti($urandom_range(0, 3), '0);

        do_irq(N'(1) << 5, c_all, 1'b1, 16'h0600);
        do_reti(TO, '0);
        chk_flags();

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                do_reti(($urandom_range(0, 9) == 0) ? TO + 1 : $urandom_range(0, 4), '0);
            end else begin
                do_irq(N'($urandom) & N'($urandom), N'($urandom) | N'($urandom),
                       $urandom_range(0, 3) != 0, AW'($urandom));
            end
            chk_flags();
        end
        while (stk.size() > 0) do_reti($urandom_range(0, 3), '0);

        irq_req = N'(1); irq_mask = c_all; instr_boundary = 1'b1; pc_next = 16'h0700;
        step();
        chk("save_before_rst", int_set, 1);
        rst = 1'b0;
        irq_req = '0; instr_boundary = 1'b0;
        step();
        stk.delete(); m_uf = 1'b0; m_to = 1'b0; m_ret_addr = '0;
        chk("abort_int_set", int_set, 0);
        chk("abort_irq_ack", irq_ack, 0);
        chk("abort_ret_addr", ret_addr, 0);
        chk("abort_jump_valid", jump_valid, 0);
        chk("abort_nest_depth", nest_depth, 0);
        chk("abort_busy", busy, 0);
        chk_flags();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("post_rst_no_strobe", {int_set, ret_valid, jump_valid}, 0);
        end
        do_irq(N'(4'b0010), c_all, 1'b1, 16'h0800);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/int_ctrl.md
# int_ctrl

Interrupt controller that sits directly upstream of the AP interrupt context stack. It arbitrates external interrupt requests at instruction boundaries and drives the stack's save and restore strobes. It also issues the ISR vector jump, and on a return-from-interrupt issues the restore strobe, waits for the restored context, and hands the return address back to the AP controller's fetch stage. It tracks nesting depth and priority so the stack never overflows or underflows.

## Interface
- NUM_IRQ, 4: number of interrupt request lines; index 0 has the highest priority.
- ADDR_WIDTH_MEM, 16: instruction address width.
- STACK_DEPTH, 8: maximum nesting depth; must match the context stack.
- ISR_BASE, 16'h0100: vector address of IRQ 0.
- ISR_STRIDE, 16'h0040: spacing between vectors.
- CTXT_TIMEOUT, 15: cycles allowed for ctxt_rdy after a restore strobe.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- irq_req  in  NUM_IRQ  level-sensitive requests.
- irq_mask  in  NUM_IRQ  1 = line enabled.
- instr_boundary  in  1  AP controller is at a safe interrupt point.
- pc_next  in  ADDR_WIDTH_MEM  address to resume at after the ISR.
- reti  in  1  single-cycle return-from-interrupt pulse.
- ctxt_rdy  in  1  context stack has restored data.
- ret_addr_ret  in  ADDR_WIDTH_MEM  restored return address from the stack.
- int_set  out  1  save strobe to the stack.
- ret_valid  out  1  restore strobe to the stack.
- ret_addr  out  ADDR_WIDTH_MEM  return address presented to the stack.
- jump_valid  out  1  one-cycle redirect for fetch.
- jump_addr  out  ADDR_WIDTH_MEM  redirect target.
- irq_ack  out  NUM_IRQ  one-hot acknowledge pulse.
- nest_depth  out  $clog2(STACK_DEPTH)+1  current nesting level.
- busy  out  1  FSM is not IDLE.
- err_underflow  out  1  sticky; set on reti at depth 0.
- err_timeout  out  1  sticky; set when ctxt_rdy does not arrive.

## Operation
- FSM states: IDLE, SAVE, JUMP, RESTORE, WAIT_CTXT, RESUME.
- in_service[NUM_IRQ] is a register of active priority levels.
- cand is the lowest index with irq_req & irq_mask set.
- cand is eligible when cand < lowest set bit of in_service (or in_service == 0), nest_depth < STACK_DEPTH, and instr_boundary = 1.
- IDLE with reti = 1:
  - if nest_depth > 0, go to RESTORE;
  - otherwise set err_underflow and stay in IDLE.
  - reti takes priority over a simultaneous eligible request.
- IDLE with an eligible cand: latch ret_addr <= pc_next and id <= cand, then go to SAVE.
- SAVE:
  - int_set = 1, irq_ack[id] = 1;
  - set in_service[id];
  - nest_depth + 1;
  - go to JUMP.
- JUMP: jump_valid = 1, jump_addr = ISR_BASE + id*ISR_STRIDE (truncated to ADDR_WIDTH_MEM); go to IDLE.
- RESTORE:
  - ret_valid = 1;
  - clear the lowest set bit of in_service;
  - nest_depth - 1;
  - clear the timeout counter;
  - go to WAIT_CTXT.
- WAIT_CTXT:
  - on ctxt_rdy = 1, latch ret_addr_ret and go to RESUME;
  - otherwise the counter increments; when it reaches CTXT_TIMEOUT, set err_timeout and go to IDLE with no redirect.
- RESUME: jump_valid = 1, jump_addr = latched address; go to IDLE.
- ret_addr holds its value until the next IDLE→SAVE latch, so the stack samples a stable value in the cycle after the int_set edge.
- Full condition: when nest_depth = STACK_DEPTH, requests stay pending with no acknowledge.
- Masking a line while it is in service does not clear in_service.

## Timing
- All outputs are registered. Reset values: all outputs 0, ret_addr 0, in_service 0, FSM in IDLE.
- int_set and ret_valid are high for exactly one cycle. Because both paths pass through IDLE, the stack's edge detector always sees a low cycle between strobes.
- Interrupt latency: accept at cycle N, int_set at N+1, jump_valid at N+2, back in IDLE at N+3.
- Return: reti at cycle N, ret_valid at N+1, ctxt_rdy expected at N+3, jump_valid at N+4.
- Earliest re-acceptance is the cycle after the controller returns to IDLE.
- Reset in the middle of an operation aborts immediately. No strobe is emitted after reset deasserts.

## Structure
- Shared package int_pkg holds:
  - the state enum;
  - the ISR_BASE/ISR_STRIDE defaults;
  - the depth width function.
- One sub-module, int_prio_enc: a combinational lowest-index-first encoder with valid output, used for both cand and the lowest in_service bit.

## Test plan
- irq_req=4'b0100, mask all, boundary=1, pc_next=16'h0020 → int_set pulse, irq_ack=4'b0100, jump_addr=16'h0180, ret_addr=16'h0020, nest_depth=1.
- While IRQ 2 is in service, raise IRQ 3, then IRQ 1 → IRQ 3 is ignored; IRQ 1 nests with jump_addr=16'h0140 and nest_depth=2.
- reti with a stack model that returns ctxt_rdy 2 cycles later and ret_addr_ret=16'h0020 → ret_valid pulse, jump_valid with 16'h0020, nest_depth decrements, in_service cleared.
- reti at depth 0 → no ret_valid, err_underflow=1; a request in the same cycle as reti at depth 1 → restore first, interrupt accepted afterwards.
- Nest 8 deep, then a 9th request → held pending, no int_set; after one reti it is accepted.
- ctxt_rdy held low → err_timeout after 15 WAIT_CTXT cycles, FSM returns to IDLE; assert rst mid-SAVE → all outputs 0 on the next edge.
